fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Front-end controller of the ECAP5-DPROC core. Owns the program counter, issues instruction fetch requests to memory, holds each fetched instruction for decode behind a valid/ready handshake, and redirects the PC on taken branches, interrupts, debug requests and debug return. Redirect targets are the core constants `boot_address` (32'h00000000), `interrupt_address` (32'hFF00000A) and `debug_address` (32'hFF00000B).

## Interface
- No parameters; all addresses come from `ecap5_dproc_pkg`.
- clk_i  in  1  core clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- fetch_req_o  out  1  fetch request; address stable while asserted.
- fetch_addr_o  out  32  fetch address, equal to the internal PC.
- fetch_ack_i  in  1  memory accepts the request; `instr_i` is valid in the same cycle.
- instr_i  in  32  fetched instruction word.
- output_valid_o  out  1  `instr_o` and `pc_o` are valid for decode.
- output_ready_i  in  1  decode accepts the instruction.
- instr_o  out  32  held instruction.
- pc_o  out  32  address of `instr_o`.
- branch_i  in  1  taken-branch redirect, one-cycle pulse.
- branch_target_i  in  32  branch target.
- irq_i  in  1  level interrupt request.
- irq_en_i  in  1  interrupt enable.
- drq_i  in  1  debug request, level.
- dret_i  in  1  debug return, one-cycle pulse.
- epc_o  out  32  saved return PC.
- irq_taken_o  out  1  one-cycle pulse when an interrupt is taken.
- debug_taken_o  out  1  one-cycle pulse when debug mode is entered.
- debug_mode_o  out  1  high while the core is in debug mode.

## Operation
- **States:**
  - FLUSH: `fetch_req_o`=0. Unconditionally goes to FETCH next cycle.
  - FETCH: `fetch_req_o`=1, `fetch_addr_o`=PC.
  - HOLD: `output_valid_o`=1.
- **Reset state** is FLUSH. Reset values: PC=32'h00000000; `instr_o`, `pc_o`, `epc_o`=0; all 1-bit outputs=0.
- **FETCH, ack, no redirect:** `instr_o`<=`instr_i`, `pc_o`<=PC, PC<=PC+4 (mod 2^32, so 32'hFFFFFFFC wraps to 0), go to HOLD.
- **FETCH, no ack:** stay in FETCH, address unchanged.
- **HOLD:** with `output_ready_i`=1, go to FETCH; otherwise stay, with `instr_o` and `pc_o` held stable.
- **Redirect priority** (fixed): `dret_i` (only when `debug_mode_o`=1) > debug (`drq_i` && !`debug_mode_o`) > irq (`irq_i` && `irq_en_i` && !`debug_mode_o`) > `branch_i`.
- **Redirect handling:** evaluated every cycle in every state. The winning redirect loads PC with its target, clears `output_valid_o`, and goes to FLUSH. A held instruction or a same-cycle `fetch_ack_i` instruction is discarded.
- **Targets:**
  - dret: `epc_o`; also clears `debug_mode_o`.
  - debug: `debug_address`; sets `debug_mode_o`, pulses `debug_taken_o`.
  - irq: `interrupt_address`; pulses `irq_taken_o`.
  - branch: `branch_target_i`.
- **`epc_o` capture** (debug and irq only; branch and dret leave it unchanged):
  - If `branch_i` is asserted in the same cycle, capture `branch_target_i` (the branch completed).
  - Else, in HOLD with `output_ready_i`=0, capture `pc_o` (the held instruction was not consumed).
  - Else capture PC.
- **Handshake plus redirect:** a HOLD handshake (`output_ready_i`=1) in the same cycle as a redirect counts as consumed by decode.
- Debug entry overwrites `epc_o`. `irq_i` is ignored in debug mode.

## Timing
- Reset released at cycle 0 (FLUSH). First request with address 0 is at cycle 1.
- Fetch-to-decode latency is 1 cycle: `output_valid_o` rises the cycle after `fetch_ack_i`.
- Maximum throughput is one instruction every 2 cycles.
- Redirect penalty: sampled at cycle N, FLUSH at N+1, request to the new target at N+2.
- `irq_taken_o`, `debug_taken_o`, `debug_mode_o` and `epc_o` change at the edge after the redirect is sampled.
- A redirect in FLUSH updates PC and restarts FLUSH.
- `output_valid_o` never drops without a handshake except on redirect or reset.
- Reset asserted mid-operation overrides everything at the next edge.

## Test plan
- **Reset and boot:** release reset; memory acks every request with 32'h00000013. Expect requests at 0x0, 0x4, 0x8, `pc_o` following the same sequence, `output_valid_o` high every other cycle.
- **Backpressure:** hold `output_ready_i`=0 for 5 cycles in HOLD. Expect `instr_o`/`pc_o` stable, `fetch_req_o`=0, and resumption at PC+4 after ready.
- **Branch during FETCH with same-cycle ack:** `branch_i`=1, target 0x100. Expect the ack'd instruction discarded, one FLUSH cycle, then a request at 0x100.
- **Interrupt in HOLD with `pc_o`=0x20, ready=0:** expect `irq_taken_o` pulse, `epc_o`=0x20, request at 0xFF00000A two cycles later. Repeat with `irq_en_i`=0: no effect.
- **Simultaneous `branch_i` (target 0x40) and `irq_i`:** expect irq wins, `epc_o`=0x40.
- **Debug then dret:** assert `drq_i` at PC=0x10. Expect `debug_mode_o`=1, `epc_o`=0x10, fetch at 0xFF00000B, `irq_i` ignored. Pulse `dret_i`: expect `debug_mode_o`=0 and a fetch at 0x10.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ECAP5-DPROC front end: owns the PC, issues fetches, and holds each fetched
// instruction for decode behind a valid/ready handshake with redirects.
package ecap5_dproc_pkg;
  localparam logic [31:0] boot_address      = 32'h00000000;
  localparam logic [31:0] interrupt_address = 32'hFF00000A;
  localparam logic [31:0] debug_address     = 32'hFF00000B;
endpackage

module fetch_sequencer
  import ecap5_dproc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        fetch_req_o,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_ack_i,
  input  logic [31:0] instr_i,
  output logic        output_valid_o,
  input  logic        output_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        irq_i,
  input  logic        irq_en_i,
  input  logic        drq_i,
  input  logic        dret_i,
  output logic [31:0] epc_o,
  output logic        irq_taken_o,
  output logic        debug_taken_o,
  output logic        debug_mode_o
);

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state;
  logic [31:0] pc;

  logic        take_dret;
  logic        take_debug;
  logic        take_irq;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc_capture;

  assign fetch_addr_o = pc;

  // Debug return and debug entry are mutually exclusive through debug_mode_o.
  assign take_dret  = dret_i && debug_mode_o;
  assign take_debug = drq_i && !debug_mode_o;
  assign take_irq   = irq_i && irq_en_i && !debug_mode_o;
  assign redirect   = take_dret || take_debug || take_irq || branch_i;

  always_comb begin
    redirect_pc = branch_target_i;
    if (take_dret) begin
      redirect_pc = epc_o;
    end else if (take_debug) begin
      redirect_pc = debug_address;
    end else if (take_irq) begin
      redirect_pc = interrupt_address;
    end
  end

  // Return point: a coincident branch has completed; an unconsumed held
  // instruction must be re-executed; otherwise resume at the current PC.
  always_comb begin
    epc_capture = pc;
    if (branch_i) begin
      epc_capture = branch_target_i;
    end else if (state == HOLD && !output_ready_i) begin
      epc_capture = pc_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= FLUSH;
      pc             <= boot_address;
      fetch_req_o    <= 1'b0;
      output_valid_o <= 1'b0;
      instr_o        <= 32'h0;
      pc_o           <= 32'h0;
      epc_o          <= 32'h0;
      irq_taken_o    <= 1'b0;
      debug_taken_o  <= 1'b0;
      debug_mode_o   <= 1'b0;
    end else begin
      irq_taken_o   <= 1'b0;
      debug_taken_o <= 1'b0;
      if (redirect) begin
        state          <= FLUSH;
        pc             <= redirect_pc;
        fetch_req_o    <= 1'b0;
        output_valid_o <= 1'b0;
        if (take_dret) begin
          debug_mode_o <= 1'b0;
        end else if (take_debug) begin
          debug_mode_o  <= 1'b1;
          debug_taken_o <= 1'b1;
          epc_o         <= epc_capture;
        end else if (take_irq) begin
          irq_taken_o <= 1'b1;
          epc_o       <= epc_capture;
        end
      end else begin
        case (state)
          FLUSH: begin
            state       <= FETCH;
            fetch_req_o <= 1'b1;
          end
          FETCH: begin
            if (fetch_ack_i) begin
              instr_o        <= instr_i;
              pc_o           <= pc;
              pc             <= pc + 32'd4;
              state          <= HOLD;
              fetch_req_o    <= 1'b0;
              output_valid_o <= 1'b1;
            end
          end
          HOLD: begin
            if (output_ready_i) begin
              state          <= FETCH;
              fetch_req_o    <= 1'b1;
              output_valid_o <= 1'b0;
            end
          end
          default: begin
            state          <= FLUSH;
            fetch_req_o    <= 1'b0;
            output_valid_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a memory model acks requests and the
// expected decode-side outputs are queued per accepted fetch.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        fetch_req_o;
  logic [31:0] fetch_addr_o;
  logic        fetch_ack_i = 1'b0;
  logic [31:0] instr_i = 32'h0;
  logic        output_valid_o;
  logic        output_ready_i = 1'b1;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        irq_i = 1'b0;
  logic        irq_en_i = 1'b1;
  logic        drq_i = 1'b0;
  logic        dret_i = 1'b0;
  logic [31:0] epc_o;
  logic        irq_taken_o;
  logic        debug_taken_o;
  logic        debug_mode_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        total = 0;
  int        bad = 0;
  logic      auto_ack = 1'b0;
  logic      exp_mode = 1'b0;

  fetch_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .fetch_req_o     (fetch_req_o),
    .fetch_addr_o    (fetch_addr_o),
    .fetch_ack_i     (fetch_ack_i),
    .instr_i         (instr_i),
    .output_valid_o  (output_valid_o),
    .output_ready_i  (output_ready_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .irq_i           (irq_i),
    .irq_en_i        (irq_en_i),
    .drq_i           (drq_i),
    .dret_i          (dret_i),
    .epc_o           (epc_o),
    .irq_taken_o     (irq_taken_o),
    .debug_taken_o   (debug_taken_o),
    .debug_mode_o    (debug_mode_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[23:0], 8'h13};
  endfunction

  // One clock: memory responds, the scoreboard is updated from the bench's
  // own view of redirects, then the decode side is compared after the edge.
  task automatic step();
    logic      redir;
    sb_entry_t e;
    fetch_ack_i = auto_ack && (fetch_req_o === 1'b1);
    instr_i = fetch_ack_i ? mem_word(fetch_addr_o) : 32'hDEADBEEF;
    redir = (dret_i && exp_mode) || (drq_i && !exp_mode) ||
            (irq_i && irq_en_i && !exp_mode) || branch_i;
    if (rst_i || redir) begin
      sb_q.delete();
    end else begin
      if (sb_q.size() > 0 && output_ready_i) void'(sb_q.pop_front());
      if (fetch_ack_i) begin
        e.pc = fetch_addr_o;
        e.instr = mem_word(fetch_addr_o);
        sb_q.push_back(e);
      end
    end
    if (rst_i) exp_mode = 1'b0;
    else if (dret_i && exp_mode) exp_mode = 1'b0;
    else if (drq_i && !exp_mode) exp_mode = 1'b1;
    @(posedge clk);
    #1;
    branch_i = 1'b0;
    dret_i = 1'b0;
    fetch_ack_i = 1'b0;
    total++;
    if (debug_mode_o !== exp_mode) begin
      bad++;
      $display("[TB] FAIL sb_mode: debug_mode_o=%b want %b", debug_mode_o, exp_mode);
    end
    total++;
    if (sb_q.size() > 0) begin
      if (output_valid_o !== 1'b1 || instr_o !== sb_q[0].instr || pc_o !== sb_q[0].pc) begin
        bad++;
        $display("[TB] FAIL sb_out: valid=%b instr=%h pc=%h want valid=1 instr=%h pc=%h",
                 output_valid_o, instr_o, pc_o, sb_q[0].instr, sb_q[0].pc);
      end
    end else if (output_valid_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sb_valid: output_valid_o=%b want 0", output_valid_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    auto_ack = 1'b0;
    step();
    step();
    total++;
    if (fetch_req_o !== 1'b0 || fetch_addr_o !== 32'h0 || instr_o !== 32'h0 ||
        pc_o !== 32'h0 || epc_o !== 32'h0 || irq_taken_o !== 1'b0 || debug_taken_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_vals: req=%b addr=%h instr=%h pc=%h epc=%h irq=%b dbg=%b want all 0",
               fetch_req_o, fetch_addr_o, instr_o, pc_o, epc_o, irq_taken_o, debug_taken_o);
    end
    rst_i = 1'b0;
    auto_ack = 1'b1;
    step();
    total++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h0) begin
      bad++;
      $display("[TB] FAIL first_req: req=%b addr=%h want req=1 addr=00000000", fetch_req_o, fetch_addr_o);
    end
  endtask

  task automatic test_boot();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'(4 * k)) begin
        bad++;
        $display("[TB] FAIL boot_req: req=%b addr=%h want req=1 addr=%h", fetch_req_o, fetch_addr_o, 32'(4 * k));
      end
      step();
      total++;
      if (fetch_req_o !== 1'b0) begin
        bad++;
        $display("[TB] FAIL boot_hold_req: req=%b want 0", fetch_req_o);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    auto_ack = 1'b0;
    step();
    step();
    total++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'hC) begin
      bad++;
      $display("[TB] FAIL noack_stay: req=%b addr=%h want req=1 addr=0000000c", fetch_req_o, fetch_addr_o);
    end
    auto_ack = 1'b1;
    output_ready_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (fetch_req_o !== 1'b0 || pc_o !== 32'hC || instr_o !== mem_word(32'hC)) begin
        bad++;
        $display("[TB] FAIL bp_hold: req=%b pc=%h instr=%h want req=0 pc=0000000c instr=%h",
                 fetch_req_o, pc_o, instr_o, mem_word(32'hC));
      end
    end
    output_ready_i = 1'b1;
    step();
    total++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h10) begin
      bad++;
      $display("[TB] FAIL bp_resume: req=%b addr=%h want req=1 addr=00000010", fetch_req_o, fetch_addr_o);
    end
  endtask

  task automatic test_branch();
    branch_i = 1'b1;
    branch_target_i = 32'h100;
    step();
    total++;
    if (fetch_req_o !== 1'b0 || epc_o !== 32'h0) begin
      bad++;
      $display("[TB] FAIL br_flush: req=%b epc=%h want req=0 epc=00000000", fetch_req_o, epc_o);
    end
    step();
    total++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h100) begin
      bad++;
      $display("[TB] FAIL br_target: req=%b addr=%h want req=1 addr=00000100", fetch_req_o, fetch_addr_o);
    end
  endtask

  task automatic test_irq();
    branch_i = 1'b1;
    branch_target_i = 32'h20;
    step();
    step();
    output_ready_i = 1'b0;
    step();
    total++;
    if (pc_o !== 32'h20) begin
      bad++;
      $display("[TB] FAIL irq_setup: pc_o=%h want 00000020", pc_o);
    end
    irq_i = 1'b1;
    step();
    irq_i = 1'b0;
    total++;
    if (irq_taken_o !== 1'b1 || epc_o !== 32'h20 || fetch_req_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL irq_take: taken=%b epc=%h req=%b want taken=1 epc=00000020 req=0",
               irq_taken_o, epc_o, fetch_req_o);
    end
    step();
    total++;
    if (irq_taken_o !== 1'b0 || fetch_req_o !== 1'b1 || fetch_addr_o !== 32'hFF00000A) begin
      bad++;
      $display("[TB] FAIL irq_vector: taken=%b req=%b addr=%h want taken=0 req=1 addr=ff00000a",
               irq_taken_o, fetch_req_o, fetch_addr_o);
    end
    output_ready_i = 1'b1;
    step();
    output_ready_i = 1'b0;
    irq_i = 1'b1;
    irq_en_i = 1'b0;
    step();
    total++;
    if (irq_taken_o !== 1'b0 || epc_o !== 32'h20 || fetch_req_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL irq_masked: taken=%b epc=%h req=%b want taken=0 epc=00000020 req=0",
               irq_taken_o, epc_o, fetch_req_o);
    end
    irq_i = 1'b0;
    irq_en_i = 1'b1;
    output_ready_i = 1'b1;
    step();
    total++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'hFF00000E) begin
      bad++;
      $display("[TB] FAIL irq_masked_next: req=%b addr=%h want req=1 addr=ff00000e", fetch_req_o, fetch_addr_o);
    end
  endtask

  task automatic test_branch_irq();
    branch_i = 1'b1;
    branch_target_i = 32'h40;
    irq_i = 1'b1;
    step();
    irq_i = 1'b0;
    total++;
    if (irq_taken_o !== 1'b1 || epc_o !== 32'h40) begin
      bad++;
      $display("[TB] FAIL brirq_epc: taken=%b epc=%h want taken=1 epc=00000040", irq_taken_o, epc_o);
    end
    step();
    total++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'hFF00000A) begin
      bad++;
      $display("[TB] FAIL brirq_vector: req=%b addr=%h want req=1 addr=ff00000a", fetch_req_o, fetch_addr_o);
    end
  endtask

  task automatic test_debug();
    branch_i = 1'b1;
    branch_target_i = 32'h10;
    step();
    step();
    total++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h10) begin
      bad++;
      $display("[TB] FAIL dbg_setup: req=%b addr=%h want req=1 addr=00000010", fetch_req_o, fetch_addr_o);
    end
    drq_i = 1'b1;
    step();
    total++;
    if (debug_taken_o !== 1'b1 || epc_o !== 32'h10 || fetch_req_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL dbg_enter: taken=%b epc=%h req=%b want taken=1 epc=00000010 req=0",
               debug_taken_o, epc_o, fetch_req_o);
    end
    step();
    total++;
    if (debug_taken_o !== 1'b0 || fetch_req_o !== 1'b1 || fetch_addr_o !== 32'hFF00000B) begin
      bad++;
      $display("[TB] FAIL dbg_vector: taken=%b req=%b addr=%h want taken=0 req=1 addr=ff00000b",
               debug_taken_o, fetch_req_o, fetch_addr_o);
    end
    irq_i = 1'b1;
    step();
    step();
    total++;
    if (irq_taken_o !== 1'b0 || epc_o !== 32'h10 || fetch_addr_o !== 32'hFF00000F) begin
      bad++;
      $display("[TB] FAIL dbg_irq_ignored: taken=%b epc=%h addr=%h want taken=0 epc=00000010 addr=ff00000f",
               irq_taken_o, epc_o, fetch_addr_o);
    end
    irq_i = 1'b0;
    drq_i = 1'b0;
    dret_i = 1'b1;
    step();
    total++;
    if (fetch_req_o !== 1'b0 || epc_o !== 32'h10) begin
      bad++;
      $display("[TB] FAIL dret_flush: req=%b epc=%h want req=0 epc=00000010", fetch_req_o, epc_o);
    end
    step();
    total++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h10) begin
      bad++;
      $display("[TB] FAIL dret_return: req=%b addr=%h want req=1 addr=00000010", fetch_req_o, fetch_addr_o);
    end
  endtask

  task automatic test_back_to_back();
    branch_i = 1'b1;
    branch_target_i = 32'hFFFFFFFC;
    step();
    step();
    total++;
    if (fetch_addr_o !== 32'hFFFFFFFC) begin
      bad++;
      $display("[TB] FAIL wrap_setup: addr=%h want fffffffc", fetch_addr_o);
    end
    step();
    step();
    total++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h0) begin
      bad++;
      $display("[TB] FAIL wrap_pc: req=%b addr=%h want req=1 addr=00000000", fetch_req_o, fetch_addr_o);
    end
    branch_i = 1'b1;
    branch_target_i = 32'h200;
    step();
    branch_i = 1'b1;
    branch_target_i = 32'h300;
    step();
    total++;
    if (fetch_req_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_redirect: req=%b want 0", fetch_req_o);
    end
    step();
    total++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h300) begin
      bad++;
      $display("[TB] FAIL flush_target: req=%b addr=%h want req=1 addr=00000300", fetch_req_o, fetch_addr_o);
    end
  endtask

  task automatic test_mid_reset();
    step();
    drq_i = 1'b1;
    step();
    drq_i = 1'b0;
    total++;
    if (epc_o !== 32'h304) begin
      bad++;
      $display("[TB] FAIL dbg_consumed_epc: epc=%h want 00000304", epc_o);
    end
    rst_i = 1'b1;
    step();
    total++;
    if (epc_o !== 32'h0 || fetch_req_o !== 1'b0 || fetch_addr_o !== 32'h0 ||
        instr_o !== 32'h0 || pc_o !== 32'h0) begin
      bad++;
      $display("[TB] FAIL mid_reset: epc=%h req=%b addr=%h instr=%h pc=%h want all 0",
               epc_o, fetch_req_o, fetch_addr_o, instr_o, pc_o);
    end
    rst_i = 1'b0;
    step();
    total++;
    if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reboot_req: req=%b addr=%h want req=1 addr=00000000", fetch_req_o, fetch_addr_o);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_branch();
    test_irq();
    test_branch_irq();
    test_debug();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time expired before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
